intt_bu_pipe: RTL and testbench

INTT_BU_PIPE -- requirements
Module: intt_bu_pipe

---
 rtl/intt_bu_pipe.sv | 98 +++++++++
 tb/tb_intt_bu_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/intt_bu_pipe.sv
// Pipelined Gentleman-Sande inverse NTT butterfly with valid/ready flow control.
// Optional macro INTT_BU_HALVE_EN scales both results by 2^-1 mod Q.
module intt_bu_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned Val_Q      = 8380417
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o
);

  localparam logic [DATA_WIDTH-1:0] QW = DATA_WIDTH'(Val_Q);

`ifdef INTT_BU_HALVE_EN
  // x < Q < 2^(W-1), so x+Q cannot overflow DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] halve(input logic [DATA_WIDTH-1:0] x);
    return x[0] ? ((x + QW) >> 1) : (x >> 1);
  endfunction
`endif

  // Capture register feeding S1, then one register per stage.
  logic                  v0, v1, v2;
  logic [DATA_WIDTH-1:0] a0, b0, w0;
  logic [DATA_WIDTH-1:0] a1, b1, w1;
  logic [DATA_WIDTH-1:0] sum2, dif2, w2;

  logic                    adv;
  logic [DATA_WIDTH-1:0]   a_red, b_red, w_red;
  logic [DATA_WIDTH-1:0]   sum_raw, sum_mod, dif_mod;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   mul_red, res1, res2;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign adv        = in_ready_o;

  always_comb begin
    a_red   = a0 % QW;
    b_red   = b0 % QW;
    w_red   = w0 % QW;
    sum_raw = a1 + b1;
    sum_mod = (sum_raw >= QW) ? (sum_raw - QW) : sum_raw;
    dif_mod = (a1 >= b1) ? (a1 - b1) : (a1 - b1 + QW);
    prod    = {{DATA_WIDTH{1'b0}}, dif2} * {{DATA_WIDTH{1'b0}}, w2};
    mul_red = DATA_WIDTH'(prod % {{DATA_WIDTH{1'b0}}, QW});
`ifdef INTT_BU_HALVE_EN
    res1    = halve(sum2);
    res2    = halve(mul_red);
`else
    res1    = sum2;
    res2    = mul_red;
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v0          <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_o <= 1'b0;
      a0          <= '0;
      b0          <= '0;
      w0          <= '0;
      a1          <= '0;
      b1          <= '0;
      w1          <= '0;
      sum2        <= '0;
      dif2        <= '0;
      w2          <= '0;
      data1_o     <= '0;
      data2_o     <= '0;
    end else if (adv) begin
      v0          <= in_valid_i;
      a0          <= data1_i;
      b0          <= data2_i;
      w0          <= w_i;
      v1          <= v0;
      a1          <= a_red;
      b1          <= b_red;
      w1          <= w_red;
      v2          <= v1;
      sum2        <= sum_mod;
      dif2        <= dif_mod;
      w2          <= w1;
      out_valid_o <= v2;
      data1_o     <= res1;
      data2_o     <= res2;
    end
  end

endmodule

// File: tb/tb_intt_bu_pipe.sv
// Directed self-checking bench for intt_bu_pipe (Q = 8380417).
module tb_intt_bu_pipe;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] Q = 32'd8380417;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] data1_i, data2_i, w_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] data1_o, data2_o;

  int checks = 0;
  int errors = 0;

  intt_bu_pipe #(.DATA_WIDTH(W), .Val_Q(8380417)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .w_i        (w_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .data1_o    (data1_o),
    .data2_o    (data2_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected results are given unscaled; the halving build divides by 2 mod Q.
  function automatic logic [W-1:0] scale(input logic [W-1:0] x);
`ifdef INTT_BU_HALVE_EN
    return x[0] ? ((x + Q) >> 1) : (x >> 1);
`else
    return x;
`endif
  endfunction

  // One isolated beat: accepted at the next edge, result after exactly 3 more edges.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] w, input logic [W-1:0] e1, input logic [W-1:0] e2);
    @(negedge clk);
    check_val({tag, "_ready"}, W'(in_ready_o), 32'd1);
    in_valid_i = 1'b1; data1_i = a; data2_i = b; w_i = w;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (k < 3) check_val({tag, "_early_valid"}, W'(out_valid_o), 32'd0);
    end
    @(posedge clk); #1;
    check_val({tag, "_valid"}, W'(out_valid_o), 32'd1);
    check_val({tag, "_d1"}, data1_o, scale(e1));
    check_val({tag, "_d2"}, data2_o, scale(e2));
    @(posedge clk); #1;
    check_val({tag, "_bubble"}, W'(out_valid_o), 32'd0);
  endtask

  logic [W-1:0] bp_a  [4] = '{32'd20, 32'd7,  32'd100, 32'd0};
  logic [W-1:0] bp_b  [4] = '{32'd7,  32'd20, 32'd1,   32'd0};
  logic [W-1:0] bp_w  [4] = '{32'd3,  32'd5,  32'd1,   32'd9};
  logic [W-1:0] bp_e1 [4] = '{32'd27, 32'd27, 32'd101, 32'd0};
  logic [W-1:0] bp_e2 [4] = '{32'd39, 32'd8380352, 32'd99, 32'd0};

  initial begin
    int n;
    reset_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    data1_i = '0; data2_i = '0; w_i = '0;
    #12;
    check_val("rst_valid", W'(out_valid_o), 32'd0);
    check_val("rst_d1", data1_o, 32'd0);
    check_val("rst_d2", data2_o, 32'd0);
    check_val("rst_ready", W'(in_ready_o), 32'd1);
    @(negedge clk); reset_i = 1'b0;

    run_one("basic",  32'd5,       32'd3,       32'd2,       32'd8, 32'd4);
    run_one("wrap1",  32'd1,       32'd2,       32'd1,       32'd3, 32'd8380416);
    run_one("wrap2",  32'd8380416, 32'd2,       32'd1,       32'd1, 32'd8380414);
    run_one("redw",   32'd10,      32'd4,       32'd8380418, 32'd14, 32'd6);
    run_one("redab",  32'd8380417, 32'd8380418, 32'd3,       32'd1, 32'd8380414);
    run_one("bigmul", 32'd0,       32'd1,       32'd8380416, 32'd1, 32'd1);
    run_one("one",    32'd1,       32'd0,       32'd1,       32'd1, 32'd1);

    // Backpressure: four back-to-back beats, stall 5 cycles once the first emerges.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1; data1_i = bp_a[i]; data2_i = bp_b[i]; w_i = bp_w[i];
      @(posedge clk);
    end
    #1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_ready_low", W'(in_ready_o), 32'd0);
      check_val("bp_hold_valid", W'(out_valid_o), 32'd1);
      check_val("bp_hold_d1", data1_o, scale(bp_e1[0]));
      check_val("bp_hold_d2", data2_o, scale(bp_e2[0]));
      @(posedge clk);
    end
    #1;
    out_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid_o) begin
        if (n < 4) begin
          check_val("bp_d1", data1_o, scale(bp_e1[n]));
          check_val("bp_d2", data2_o, scale(bp_e2[n]));
        end
        n++;
      end
    end
    check_val("bp_count", W'(n), 32'd4);

    // Reset with two beats in flight, the first one already on the outputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1; data1_i = 32'd50 + W'(i); data2_i = 32'd9; w_i = 32'd7;
      @(posedge clk);
    end
    #1;
    in_valid_i = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_valid", W'(out_valid_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check_val("mid_rst_valid", W'(out_valid_o), 32'd0);
    check_val("mid_rst_d1", data1_o, 32'd0);
    check_val("mid_rst_d2", data2_o, 32'd0);
    check_val("mid_rst_ready", W'(in_ready_o), 32'd1);
    @(negedge clk); reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("post_rst_stale", W'(out_valid_o), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
